// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: 16-entry byte FIFO with header tagging
// and read-side packet length tracking so data_out idles to zero after the parity byte.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [WIDTH:0]  mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [6:0]      pkt_cnt;
    logic [WIDTH:0]  rd_word;
    logic [6:0]      hdr_len;
    logic            do_write;
    logic            do_read;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Both requests qualify on pre-edge flags; a flush cycle discards them.
    assign do_write = write_enb && !full  && !reset && !soft_reset;
    assign do_read  = read_enb  && !empty && !reset && !soft_reset;

    assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
    assign hdr_len = 7'(rd_word[WIDTH-1:2]) + 7'd1;

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_read) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word[WIDTH-1:0];
                if (rd_word[WIDTH]) begin
                    pkt_cnt <= hdr_len;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - 7'd1;
                end
            end else if (pkt_cnt == '0) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_router_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic             clock;
    logic             reset;
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int checks   = 0;
    int failures = 0;

    router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: a queue of {header_flag, byte}, expected data_out and remaining length.
    logic [8:0] q[$];
    logic [7:0] m_dout = '0;
    int         m_cnt  = 0;

    always @(posedge clock) begin
        logic       wr_ok;
        logic       rd_ok;
        logic [8:0] e;
        if (reset || soft_reset) begin
            q.delete();
            m_dout = '0;
            m_cnt  = 0;
        end else begin
            wr_ok = write_enb && (q.size() < DEPTH);
            rd_ok = read_enb && (q.size() > 0);
            if (rd_ok) begin
                e      = q.pop_front();
                m_dout = e[7:0];
                if (e[8])            m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt != 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = '0;
            end
            if (wr_ok) q.push_back({lfd_state, data_in});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model_data_out", 32'(data_out), 32'(m_dout));
        chk("model_empty", 32'(empty), 32'(q.size() == 0));
        chk("model_full", 32'(full), 32'(q.size() == DEPTH));
    end

    task automatic cyc(input logic we, input logic re, input logic lfd,
                       input logic [7:0] d, input logic sr);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = d;
        soft_reset = sr;
        @(negedge clock);
    endtask

    initial begin
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full", 32'(full), 32'h0);
        reset = 1'b0;

        // Read on empty must not move the read pointer.
        cyc(0, 1, 0, 8'h00, 0);
        chk("underflow_empty", 32'(empty), 32'h1);
        cyc(1, 0, 0, 8'h3C, 0);
        cyc(0, 1, 0, 8'h00, 0);
        chk("after_underflow_read", 32'(data_out), 32'h3C);
        chk("after_underflow_empty", 32'(empty), 32'h1);

        // Single packet: header 0x0D => 3 payload + parity.
        cyc(1, 0, 1, 8'h0D, 0);
        cyc(1, 0, 0, 8'hA1, 0);
        cyc(1, 0, 0, 8'hA2, 0);
        cyc(1, 0, 0, 8'hA3, 0);
        cyc(1, 0, 0, 8'h5C, 0);
        cyc(0, 1, 0, 8'h00, 0); chk("pkt_hdr", 32'(data_out), 32'h0D);
        cyc(0, 1, 0, 8'h00, 0); chk("pkt_p1", 32'(data_out), 32'hA1);
        cyc(0, 1, 0, 8'h00, 0); chk("pkt_p2", 32'(data_out), 32'hA2);
        cyc(0, 1, 0, 8'h00, 0); chk("pkt_p3", 32'(data_out), 32'hA3);
        cyc(0, 1, 0, 8'h00, 0); chk("pkt_parity", 32'(data_out), 32'h5C);
        cyc(0, 0, 0, 8'h00, 0); chk("pkt_idle", 32'(data_out), 32'h00);
        chk("pkt_empty", 32'(empty), 32'h1);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 8'(8'h10 + i), 0);
        chk("fill_full", 32'(full), 32'h1);
        cyc(1, 0, 0, 8'hFF, 0);
        chk("overflow_full", 32'(full), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            chk("fill_drain", 32'(data_out), 32'(8'h10 + i));
        end
        chk("fill_drained_empty", 32'(empty), 32'h1);

        // Full with simultaneous read+write: read proceeds, 0x77 dropped.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 8'(8'h30 + i), 0);
        cyc(1, 1, 0, 8'h77, 0);
        chk("full_rw_read", 32'(data_out), 32'h30);
        chk("full_rw_notfull", 32'(full), 32'h0);
        cyc(1, 1, 0, 8'h78, 0);
        chk("next_rw_read", 32'(data_out), 32'h31);
        chk("next_rw_notfull", 32'(full), 32'h0);
        for (int i = 0; i < DEPTH - 2; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            chk("full_rw_drain", 32'(data_out), 32'(8'h32 + i));
        end
        cyc(0, 1, 0, 8'h00, 0);
        chk("full_rw_last", 32'(data_out), 32'h78);
        chk("full_rw_empty", 32'(empty), 32'h1);

        // Soft reset mid-packet (header 0x28 => length 10).
        cyc(1, 0, 1, 8'h28, 0);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 8'(8'h50 + i), 0);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_hdr", 32'(data_out), 32'h28);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_p1", 32'(data_out), 32'h50);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_p2", 32'(data_out), 32'h51);
        cyc(1, 1, 0, 8'hEE, 1);
        chk("sr_empty", 32'(empty), 32'h1);
        chk("sr_data_out", 32'(data_out), 32'h00);
        cyc(1, 0, 1, 8'h09, 0);
        cyc(1, 0, 0, 8'hC1, 0);
        cyc(1, 0, 0, 8'hC2, 0);
        cyc(1, 0, 0, 8'hEE, 0);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_new_hdr", 32'(data_out), 32'h09);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_new_p1", 32'(data_out), 32'hC1);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_new_p2", 32'(data_out), 32'hC2);
        cyc(0, 1, 0, 8'h00, 0); chk("sr_new_par", 32'(data_out), 32'hEE);
        cyc(0, 0, 0, 8'h00, 0); chk("sr_new_idle", 32'(data_out), 32'h00);

        // Wrap-around streaming: each byte read back the cycle after it is written.
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 8'(8'h80 + i), 0);
            if (i > 0) chk("wrap_stream", 32'(data_out), 32'(8'h80 + i - 1));
            chk("wrap_not_full", 32'(full), 32'h0);
        end
        cyc(0, 1, 0, 8'h00, 0);
        chk("wrap_last", 32'(data_out), 32'hA7);
        chk("wrap_empty", 32'(empty), 32'h1);

        // Randomized traffic with shifting write/read bias and rare flushes.
        for (int seg = 0; seg < 6; seg++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 30 : 55;
            rp = (seg % 3 == 0) ? 30 : (seg % 3 == 1) ? 80 : 55;
            for (int i = 0; i < 300; i++) begin
                cyc($urandom_range(0, 99) < wp,
                    $urandom_range(0, 99) < rp,
                    $urandom_range(0, 99) < 15,
                    8'($urandom),
                    $urandom_range(0, 199) == 0);
            end
        end
        reset = 1'b1;
        cyc(0, 0, 0, 8'h00, 0);
        reset = 1'b0;
        chk("final_reset_empty", 32'(empty), 32'h1);
        cyc(0, 0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
